// File: rtl/lif_param_loader.sv
// lif_param_loader: serial LSB-first loader for per-neuron tau/weight/threshold sets.
// Framed shifts land in shadow registers and commit atomically to one bank slice.
module lif_param_loader #(
    parameter int TAU_W     = 15,
    parameter int WEIGHT_W  = 11,
    parameter int THRESH_W  = 15,
    parameter int N_NEURONS = 4,
    parameter int ADDR_W    = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load_en,
    input  logic [ADDR_W-1:0]               addr,
    input  logic                            tau_sdi,
    input  logic                            weight_sdi,
    input  logic                            thresh_sdi,
    output logic [N_NEURONS*TAU_W-1:0]      tau_o,
    output logic [N_NEURONS*WEIGHT_W-1:0]   weight_o,
    output logic [N_NEURONS*THRESH_W-1:0]   thresh_o,
    output logic                            busy,
    output logic                            cfg_valid,
    output logic                            frame_err
);
    localparam int TW_MAX    = (TAU_W > WEIGHT_W) ? TAU_W : WEIGHT_W;
    localparam int FRAME_LEN = (TW_MAX > THRESH_W) ? TW_MAX : THRESH_W;
    localparam int CNT_W     = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0]  C_FL  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  C_SAT = CNT_W'(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  C_TW  = CNT_W'(TAU_W);
    localparam logic [CNT_W-1:0]  C_WW  = CNT_W'(WEIGHT_W);
    localparam logic [CNT_W-1:0]  C_HW  = CNT_W'(THRESH_W);
    localparam logic [ADDR_W:0]   C_NN  = (ADDR_W + 1)'(N_NEURONS);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [TAU_W-1:0]    r_tau_sh;
    logic [WEIGHT_W-1:0] r_wt_sh;
    logic [THRESH_W-1:0] r_th_sh;
    logic                w_good;

    assign w_good = (r_cnt == C_FL) && ({1'b0, r_addr} < C_NN);
    assign busy   = (r_state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_tau_sh  <= '0;
            r_wt_sh   <= '0;
            r_th_sh   <= '0;
            tau_o     <= '0;
            weight_o  <= '0;
            thresh_o  <= '0;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            if (r_state == IDLE) begin
                if (load_en) begin
                    r_addr    <= addr;
                    r_tau_sh  <= TAU_W'(tau_sdi);
                    r_wt_sh   <= WEIGHT_W'(weight_sdi);
                    r_th_sh   <= THRESH_W'(thresh_sdi);
                    r_cnt     <= CNT_W'(1);
                    frame_err <= 1'b0;
                    r_state   <= SHIFT;
                end
            end else if (load_en) begin
                // Narrower fields stop capturing once their width is reached.
                if (r_cnt < C_FL) begin
                    if (r_cnt < C_TW) r_tau_sh[r_cnt] <= tau_sdi;
                    if (r_cnt < C_WW) r_wt_sh[r_cnt]  <= weight_sdi;
                    if (r_cnt < C_HW) r_th_sh[r_cnt]  <= thresh_sdi;
                end
                if (r_cnt != C_SAT) r_cnt <= r_cnt + 1'b1;
            end else begin
                if (w_good) begin
                    tau_o[r_addr*TAU_W +: TAU_W]          <= r_tau_sh;
                    weight_o[r_addr*WEIGHT_W +: WEIGHT_W] <= r_wt_sh;
                    thresh_o[r_addr*THRESH_W +: THRESH_W] <= r_th_sh;
                    cfg_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                end
                r_state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_lif_param_loader.sv
// tb_lif_param_loader: directed frames with hand-computed bank contents.
module tb_lif_param_loader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_en = 1'b0;
    logic [2:0]  addr = '0;
    logic        tau_sdi = 1'b0, weight_sdi = 1'b0, thresh_sdi = 1'b0;
    logic [59:0] tau_o;
    logic [43:0] weight_o;
    logic [59:0] thresh_o;
    logic        busy, cfg_valid, frame_err;

    int n_chk = 0;
    int n_fail = 0;
    logic [14:0] exp_tau [4];
    logic [10:0] exp_w   [4];
    logic [14:0] exp_th  [4];

    lif_param_loader dut (
        .clk(clk), .rst(rst), .load_en(load_en), .addr(addr),
        .tau_sdi(tau_sdi), .weight_sdi(weight_sdi), .thresh_sdi(thresh_sdi),
        .tau_o(tau_o), .weight_o(weight_o), .thresh_o(thresh_o),
        .busy(busy), .cfg_valid(cfg_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_bank(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s tau[%0d]", tag, i), 32'(tau_o[i*15 +: 15]), 32'(exp_tau[i]));
            check($sformatf("%s w[%0d]", tag, i), 32'(weight_o[i*11 +: 11]), 32'(exp_w[i]));
            check($sformatf("%s th[%0d]", tag, i), 32'(thresh_o[i*15 +: 15]), 32'(exp_th[i]));
        end
    endtask

    // Drives nbits frame bits, then one low cycle; returns on the negedge after the frame-end edge.
    task automatic send_frame(input logic [2:0] a, input logic [31:0] t, input logic [31:0] w,
                              input logic [31:0] h, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("busy in frame", 32'(busy), 32'd1);
                check("err cleared at start", 32'(frame_err), 32'd0);
            end
            load_en = 1'b1;
            addr = (i == 0) ? a : 3'd7;
            tau_sdi = t[i];
            weight_sdi = w[i];
            thresh_sdi = h[i];
        end
        @(negedge clk);
        load_en = 1'b0;
        addr = 3'd0;
        @(negedge clk);
    endtask

    task automatic expect_good(input string tag);
        check({tag, " cfg_valid"}, 32'(cfg_valid), 32'd1);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check_bank(tag);
        @(negedge clk);
        check({tag, " cfg_valid 1-cycle"}, 32'(cfg_valid), 32'd0);
    endtask

    task automatic expect_bad(input string tag);
        check({tag, " cfg_valid"}, 32'(cfg_valid), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd1);
        check_bank(tag);
        @(negedge clk);
        check({tag, " cfg_valid later"}, 32'(cfg_valid), 32'd0);
        check({tag, " err sticky"}, 32'(frame_err), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_tau[i] = '0; exp_w[i] = '0; exp_th[i] = '0;
        end
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset cfg_valid", 32'(cfg_valid), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check_bank("reset");
        rst = 1'b0;
        @(negedge clk);

        send_frame(3'd2, 32'h1234, 32'h2AB, 32'h7FFF, 15);
        exp_tau[2] = 15'h1234; exp_w[2] = 11'h2AB; exp_th[2] = 15'h7FFF;
        expect_good("t1 addr2");

        send_frame(3'd1, 32'h3FF, 32'h3FF, 32'h3FF, 10);
        expect_bad("t2 short");

        send_frame(3'd1, 32'h0ABC, 32'h155, 32'h1357, 15);
        exp_tau[1] = 15'h0ABC; exp_w[1] = 11'h155; exp_th[1] = 15'h1357;
        expect_good("t2 recover");

        send_frame(3'd0, 32'h18111, 32'h7FF, 32'h7FFF, 17);
        expect_bad("t3 long");

        send_frame(3'd5, 32'h7FFF, 32'h7FF, 32'h7FFF, 15);
        expect_bad("t4 bad addr");

        send_frame(3'd0, 32'h1, 32'h1, 32'h1, 1);
        expect_bad("t4b one bit");

        send_frame(3'd0, 32'h7FFF, 32'h7AAA, 32'h0001, 15);
        exp_tau[0] = 15'h7FFF; exp_w[0] = 11'h2AA; exp_th[0] = 15'h0001;
        check("t5a cfg_valid", 32'(cfg_valid), 32'd1);
        check_bank("t5a");
        send_frame(3'd3, 32'h4000, 32'h7D23, 32'h2468, 15);
        exp_tau[3] = 15'h4000; exp_w[3] = 11'h523; exp_th[3] = 15'h2468;
        expect_good("t5b addr3");

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            addr = (i == 0) ? 3'd1 : 3'd0;
            tau_sdi = 1'b1; weight_sdi = 1'b1; thresh_sdi = 1'b1;
        end
        @(negedge clk);
        rst = 1'b1;
        load_en = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_tau[i] = '0; exp_w[i] = '0; exp_th[i] = '0;
        end
        check("t6 rst busy", 32'(busy), 32'd0);
        check("t6 rst cfg_valid", 32'(cfg_valid), 32'd0);
        check_bank("t6 rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6 post cfg_valid", 32'(cfg_valid), 32'd0);
        check("t6 post busy", 32'(busy), 32'd0);
        send_frame(3'd2, 32'h0F0F, 32'h0F0, 32'h3C3C, 15);
        exp_tau[2] = 15'h0F0F; exp_w[2] = 11'h0F0; exp_th[2] = 15'h3C3C;
        expect_good("t6 reload");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lif_param_loader.md
Name: lif_param_loader

Overview:
Parametrised serial configuration loader for a bank of leaky integrate-and-fire neurons. It shifts tau, weight and threshold in LSB-first on three serial lines during a framed load window, then commits them atomically to one addressed neuron's parameter set. Frame length and address are validated, and malformed frames are rejected with a sticky error flag. The block sits between the external config interface and the neuron array; each neuron reads its slice of the flat output buses.

Parameters:
TAU_W, 15, tau field width in bits
WEIGHT_W, 11, weight field width in bits
THRESH_W, 15, threshold field width in bits
N_NEURONS, 4, number of parameter sets held
ADDR_W, 3, address width; addresses >= N_NEURONS are invalid

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
load_en  in  1  frame strobe; high for exactly FRAME_LEN cycles per frame
addr  in  ADDR_W  target neuron, sampled on the frame's first cycle
tau_sdi  in  1  tau serial bit, LSB first
weight_sdi  in  1  weight serial bit, LSB first
thresh_sdi  in  1  threshold serial bit, LSB first
tau_o  out  N_NEURONS*TAU_W  committed tau; neuron i at [i*TAU_W +: TAU_W]
weight_o  out  N_NEURONS*WEIGHT_W  committed weights, same packing
thresh_o  out  N_NEURONS*THRESH_W  committed thresholds, same packing
busy  out  1  high while in SHIFT
cfg_valid  out  1  one-cycle pulse on a successful commit
frame_err  out  1  sticky error from the last rejected frame

Behaviour:
- Frame length: FRAME_LEN = max(TAU_W, WEIGHT_W, THRESH_W), 15 at defaults.
- Bit counter cnt is ceil(log2(FRAME_LEN+2)) bits wide and saturates at FRAME_LEN+1.
- Reset (async): all outputs 0, every bank entry 0, shadow registers 0, cnt 0, state IDLE.
- States: IDLE and SHIFT.
- IDLE with load_en=1:
  - latch addr into addr_q and clear the shadow registers.
  - write bit 0 of each field from its sdi line.
  - set cnt to 1, clear frame_err, enter SHIFT.
- IDLE with load_en=0: hold.
- SHIFT with load_en=1:
  - if cnt < FRAME_LEN: write shadow bit cnt of each field whose width is > cnt. Lines for narrower fields are ignored at that index.
  - cnt increments, saturating at FRAME_LEN+1. Bits beyond FRAME_LEN are discarded.
- SHIFT with load_en=0 (frame end), evaluated on that edge:
  - good frame (cnt == FRAME_LEN and addr_q < N_NEURONS): copy shadow into bank[addr_q] and assert cfg_valid for the following cycle.
  - bad frame (cnt != FRAME_LEN, or addr_q out of range): no bank change, frame_err set to 1.
  - either way, go to IDLE.
- Latency: the last data bit is sampled at edge E, load_en=0 is sampled at edge E+1, and outputs plus cfg_valid update at E+1.
- Only the addressed neuron's slice changes; all other slices hold their value.
- Back-to-back frames need at least one load_en=0 cycle between them. That low cycle is the frame end.
- busy = (state == SHIFT).
- cfg_valid and frame_err are never both asserted by the same frame.
- Reset mid-frame aborts the frame: the bank is cleared and no cfg_valid pulse occurs.
- A 1-cycle frame (cnt=1) is a short frame and sets frame_err.

Test Plan:
- Reset, then 15-bit frame to addr=2 with tau=0x1234, weight=0x2AB, thresh=0x7FFF -> one cfg_valid pulse the cycle after load_en falls; slice 2 holds those values; slices 0, 1 and 3 stay 0; frame_err=0.
- 10-bit frame to addr=1 -> frame_err=1, no cfg_valid, all outputs unchanged. A following valid 15-bit frame clears frame_err and commits.
- 17-bit frame to addr=0 with tau bits 15-16 set to 1 -> frame_err=1, slice 0 unchanged.
- Valid 15-bit frame to addr=5 -> frame_err=1, no bank slice changes.
- Two valid frames (addr=0, then addr=3) separated by one low cycle -> two cfg_valid pulses; both slices correct; weight_sdi values at bit indices 11-14 do not appear in weight_o.
- rst asserted at bit 7 of a frame -> outputs 0 immediately, busy=0, no cfg_valid; the next valid frame loads normally.
